// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_EXEC = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_WR            = 8'h01;
    localparam logic [7:0]  CMD_RD            = 8'h02;
    localparam logic [15:0] WR_ACK_WORD       = 16'h00AC;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

    function automatic logic frame_ok(input logic [15:0] hdr, input logic [15:0] data,
                                      input logic [15:0] csum);
        return (csum == (hdr ^ data)) && ((hdr[15:8] == CMD_WR) || (hdr[15:8] == CMD_RD));
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-word idle timer: counts cycles while enabled and pulses once the
// idle gap reaches TIMEOUT_CYCLES. A restart or disable clears the count.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 34720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Expiry is suppressed when a word arrives in the same cycle.
    assign expired_o = enable_i && !restart_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses sync/header/data/checksum frames into single register read/write
// transactions and returns one response word per frame.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          CLK_FREQ       = 100_000_000,
    parameter int          BAUD           = 115_200,
    parameter int          TIMEOUT_CYCLES = (CLK_FREQ / BAUD) * 40,
    parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_reg_wr,
    output logic        o_reg_rd,
    output logic [7:0]  o_reg_addr,
    output logic [15:0] o_reg_wdata,
    input  logic        i_reg_ack,
    input  logic [15:0] i_reg_rdata,
    output logic [15:0] o_resp_data,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: the request (o_reg_wr/o_reg_rd) holds until the cycle
    // i_reg_ack is sampled high; the response transfers on the cycle
    // o_resp_valid and i_resp_ready are both high.

    state_t      state_q, state_d;
    logic [15:0] hdr_q, hdr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] resp_q, resp_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_evt;
    logic        timer_en;
    logic        timer_exp;

    assign timer_en = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(i_rx_valid),
        .enable_i (timer_en),
        .expired_o(timer_exp)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_WORD)) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (i_rx_valid) begin
                    hdr_d   = i_rx_data;
                    state_d = ST_DATA;
                end else if (timer_exp) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_rx_valid) begin
                    data_d  = i_rx_data;
                    state_d = ST_CSUM;
                end else if (timer_exp) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CSUM: begin
                if (i_rx_valid) begin
                    if (frame_ok(hdr_q, data_q, i_rx_data)) begin
                        wr_d    = (hdr_q[15:8] == CMD_WR);
                        rd_d    = (hdr_q[15:8] == CMD_RD);
                        state_d = ST_EXEC;
                    end else begin
                        err_evt = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timer_exp) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                err_evt = i_rx_valid;
                if (i_reg_ack) begin
                    resp_d  = rd_q ? i_reg_rdata : WR_ACK_WORD;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                err_evt = i_rx_valid;
                if (i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hdr_q     <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_reg_wr     = wr_q;
    assign o_reg_rd     = rd_q;
    assign o_reg_addr   = hdr_q[7:0];
    assign o_reg_wdata  = data_q;
    assign o_resp_data  = resp_q;
    assign o_resp_valid = (state_q == ST_RESP);
    assign o_err_cnt    = err_cnt_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame driver, register bus
// responder, response scoreboard and error-count model.
module tb_uart_cmd_ctrl;
    localparam int T_OUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_reg_wr, o_reg_rd;
    logic [7:0]  o_reg_addr;
    logic [15:0] o_reg_wdata;
    logic        i_reg_ack = 1'b0;
    logic [15:0] i_reg_rdata = '0;
    logic [15:0] o_resp_data;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [7:0]  o_err_cnt;
    logic        o_busy;
    logic [2:0]  o_dbg_state;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(T_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd), .o_reg_addr(o_reg_addr),
        .o_reg_wdata(o_reg_wdata), .i_reg_ack(i_reg_ack), .i_reg_rdata(i_reg_rdata),
        .o_resp_data(o_resp_data), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_err_cnt(o_err_cnt), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_exp = 0;
    int ack_delay = 3;
    logic [15:0] bus_rdata = '0;

    logic [15:0] exp_q[$];   // expected response words
    logic [25:0] req_q[$];   // expected requests {wr, rd, addr, wdata}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register bus responder: checks each request, acks after ack_delay cycles.
    logic        bus_active = 1'b0;
    int          bus_cnt = 0;
    logic [25:0] bus_exp = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            i_reg_ack  = 1'b0;
            bus_active = 1'b0;
        end else if (i_reg_ack) begin
            i_reg_ack = 1'b0;
            check("req_drop", {31'd0, o_reg_wr | o_reg_rd}, 32'd0);
        end else if (o_reg_wr || o_reg_rd) begin
            if (!bus_active) begin
                if (req_q.size() == 0) begin
                    check("req_unexp", 32'd1, 32'd0);
                    bus_exp = {o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata};
                end else begin
                    bus_exp = req_q.pop_front();
                end
                bus_active = 1'b1;
                bus_cnt    = ack_delay;
            end
            check("req_kind", {30'd0, o_reg_wr, o_reg_rd}, {30'd0, bus_exp[25:24]});
            check("req_addr", {24'd0, o_reg_addr}, {24'd0, bus_exp[23:16]});
            if (bus_exp[25]) check("req_wdata", {16'd0, o_reg_wdata}, {16'd0, bus_exp[15:0]});
            if (bus_cnt == 0) begin
                i_reg_ack   = 1'b1;
                i_reg_rdata = bus_rdata;
                bus_active  = 1'b0;
            end else begin
                bus_cnt--;
            end
        end
    end

    // Response scoreboard: pops on every valid/ready transfer.
    always @(negedge clk) begin
        if (rst_n && o_resp_valid && i_resp_ready) begin
            if (exp_q.size() == 0) check("resp_unexp", {16'd0, o_resp_data}, 32'hFFFF_FFFF);
            else check("resp_data", {16'd0, o_resp_data}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic send_word(input logic [15:0] w);
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    function automatic void bump_err();
        if (err_exp < 255) err_exp++;
    endfunction

    // Sends one full frame and queues what the model expects from it.
    task automatic run_frame(input logic [15:0] hdr, input logic [15:0] data,
                             input logic [15:0] csum);
        logic good;
        good = (csum == (hdr ^ data)) && (hdr[15:8] == 8'h01 || hdr[15:8] == 8'h02);
        if (good) begin
            req_q.push_back({hdr[15:8] == 8'h01, hdr[15:8] == 8'h02, hdr[7:0], data});
            exp_q.push_back((hdr[15:8] == 8'h01) ? 16'h00AC : bus_rdata);
        end else begin
            bump_err();
        end
        send_word(16'hA55A);
        send_word(hdr);
        send_word(data);
        send_word(csum);
        check(good ? "req_lat" : "no_req", {31'd0, o_reg_wr | o_reg_rd}, {31'd0, good});
        check("frame_err", {24'd0, o_err_cnt}, err_exp);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        check("idle_wait", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        repeat (3) @(negedge clk);
        check("rst_wr", {31'd0, o_reg_wr}, 0);
        check("rst_rd", {31'd0, o_reg_rd}, 0);
        check("rst_addr", {24'd0, o_reg_addr}, 0);
        check("rst_wdata", {16'd0, o_reg_wdata}, 0);
        check("rst_rvalid", {31'd0, o_resp_valid}, 0);
        check("rst_rdata", {16'd0, o_resp_data}, 0);
        check("rst_err", {24'd0, o_err_cnt}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_state", {29'd0, o_dbg_state}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame, ack after 3 cycles.
        ack_delay = 3;
        run_frame(16'h0112, 16'hBEEF, 16'h0112 ^ 16'hBEEF);
        check("wr_flag", {31'd0, o_reg_wr}, 1);
        wait_idle(50);

        // Read frame with response held off by ready low for 5 cycles.
        bus_rdata    = 16'h1357;
        i_resp_ready = 1'b0;
        run_frame(16'h0234, 16'h0000, 16'h0234);
        check("rd_flag", {31'd0, o_reg_rd}, 1);
        vcnt = 0;
        while (!o_resp_valid && vcnt < 50) begin
            @(negedge clk);
            vcnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, o_resp_valid}, 1);
            check("hold_data", {16'd0, o_resp_data}, 32'h1357);
            @(negedge clk);
        end
        i_resp_ready = 1'b1;
        wait_idle(10);
        check("valid_low", {31'd0, o_resp_valid}, 0);

        // Bad checksum, then a good frame.
        run_frame(16'h0112, 16'hBEEF, 16'h0000);
        check("bad_busy", {31'd0, o_busy}, 0);
        bus_rdata = 16'h2468;
        run_frame(16'h0277, 16'h5555, 16'h0277 ^ 16'h5555);
        wait_idle(50);

        // Garbage in IDLE is not an error.
        send_word(16'h1234);
        send_word(16'hFFFF);
        check("garbage_err", {24'd0, o_err_cnt}, err_exp);
        check("garbage_busy", {31'd0, o_busy}, 0);

        // Timeout after the header word, exact boundary.
        send_word(16'hA55A);
        send_word(16'h0112);
        repeat (T_OUT - 1) @(negedge clk);
        check("to_before", {31'd0, o_busy}, 1);
        @(negedge clk);
        bump_err();
        check("to_err", {24'd0, o_err_cnt}, err_exp);
        check("to_idle", {31'd0, o_busy}, 0);

        // A word on the expiry cycle wins over the timeout.
        req_q.push_back({1'b1, 1'b0, 8'h12, 16'h0F0F});
        exp_q.push_back(16'h00AC);
        send_word(16'hA55A);
        send_word(16'h0112);
        repeat (T_OUT - 1) @(negedge clk);
        send_word(16'h0F0F);
        check("win_err", {24'd0, o_err_cnt}, err_exp);
        check("win_state", {29'd0, o_dbg_state}, 3);
        send_word(16'h0112 ^ 16'h0F0F);
        check("win_req", {31'd0, o_reg_wr}, 1);
        wait_idle(50);

        // Overrun during EXEC.
        ack_delay = 10;
        run_frame(16'h01A0, 16'h7777, 16'h01A0 ^ 16'h7777);
        send_word(16'h1111);
        bump_err();
        check("ovr_err", {24'd0, o_err_cnt}, err_exp);
        check("ovr_req", {31'd0, o_reg_wr}, 1);
        wait_idle(50);

        // Unknown command with a valid checksum.
        run_frame(16'h0312, 16'h0001, 16'h0312 ^ 16'h0001);

        // Saturation.
        ack_delay = 2;
        for (int i = 0; i < 300; i++) begin
            run_frame(16'h0100 | 16'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 16'hDEAD);
        end
        check("sat_err", {24'd0, o_err_cnt}, 32'hFF);

        // Reset while a write request is pending.
        ack_delay = 20;
        run_frame(16'h0156, 16'hCAFE, 16'h0156 ^ 16'hCAFE);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr", {31'd0, o_reg_wr}, 0);
        check("arst_addr", {24'd0, o_reg_addr}, 0);
        check("arst_wdata", {16'd0, o_reg_wdata}, 0);
        check("arst_err", {24'd0, o_err_cnt}, 0);
        check("arst_busy", {31'd0, o_busy}, 0);
        exp_q.delete();
        req_q.delete();
        err_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh frame after reset.
        ack_delay = 1;
        bus_rdata = 16'h9ABC;
        run_frame(16'h0201, 16'h0000, 16'h0201);
        wait_idle(50);
        check("final_err", {24'd0, o_err_cnt}, err_exp);
        check("exp_q_empty", exp_q.size(), 0);
        check("req_q_empty", req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
